// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode character RAM path.
package vga_text_pkg;

    localparam int         COLS_DEF     = 64;
    localparam int         ROWS_DEF     = 32;
    localparam int         ADDR_W_DEF   = 11;
    localparam int         DATA_W_DEF   = 8;
    localparam logic [7:0] CLR_CHAR_DEF = 8'h20;
    localparam int         TEXT_DEPTH   = COLS_DEF * ROWS_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; pointer advances past the winner on every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Grant decode: single requester wins outright, contention resolved by pointer.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

    // Pointer update: after a grant to writer 0 favour writer 1 and vice versa.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (gnt != 2'b00) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM arbiter: display fetch > clear engine > round-robin writers.
module text_ram_arbiter
    import vga_text_pkg::*;
#(
    parameter int                COLS     = COLS_DEF,
    parameter int                ROWS     = ROWS_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] CLR_CHAR = CLR_CHAR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr0_valid,
    output logic              wr0_ready,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_valid,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              oob_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int DEPTH = COLS * ROWS;

    clr_state_e        state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              disp_d1_r;
    logic              wr_en_s;
    logic [1:0]        wr_gnt_s;
    logic [ADDR_W-1:0] wr_sel_addr_s;
    logic [DATA_W-1:0] wr_sel_data_s;
    logic              wr_oob_s;
    logic              clr_write_s;
    logic              clr_last_s;

    // Writers only see the port when neither the display nor the clear engine owns it.
    assign wr_en_s = rst_n & ~disp_req & (state_r == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en_s),
        .req   ({wr1_valid, wr0_valid}),
        .gnt   (wr_gnt_s)
    );

    assign wr0_ready = wr_gnt_s[0];
    assign wr1_ready = wr_gnt_s[1];

    // Selected writer payload and out-of-buffer detection (compared at full int width).
    always_comb begin
        if (wr_gnt_s[1]) begin
            wr_sel_addr_s = wr1_addr;
            wr_sel_data_s = wr1_data;
        end else begin
            wr_sel_addr_s = wr0_addr;
            wr_sel_data_s = wr0_data;
        end
        wr_oob_s = (32'(wr_sel_addr_s) >= 32'(DEPTH));
    end

    // RAM port owner mux; an out-of-range accepted write leaves the port idle.
    always_comb begin
        ram_addr    = {ADDR_W{1'b0}};
        ram_we      = 1'b0;
        ram_wdata   = {DATA_W{1'b0}};
        clr_write_s = 1'b0;
        if (!rst_n) begin
            ram_we = 1'b0;
        end else if (disp_req) begin
            ram_addr = disp_addr;
        end else if (state_r == CLEAR) begin
            ram_we      = 1'b1;
            ram_addr    = clr_ptr_r;
            ram_wdata   = CLR_CHAR;
            clr_write_s = 1'b1;
        end else if ((wr_gnt_s != 2'b00) && !wr_oob_s) begin
            ram_we    = 1'b1;
            ram_addr  = wr_sel_addr_s;
            ram_wdata = wr_sel_data_s;
        end else begin
            ram_we = 1'b0;
        end
    end

    assign clr_last_s = clr_write_s && (clr_ptr_r == ADDR_W'(DEPTH - 1));

    // Clear FSM: walks the whole buffer, stalling on display cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            clr_ptr_r <= {ADDR_W{1'b0}};
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (clr_start) begin
                        state_r   <= CLEAR;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                        clr_busy  <= 1'b1;
                    end else begin
                        clr_busy <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_last_s) begin
                        state_r  <= IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else if (clr_write_s) begin
                        clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        clr_ptr_r <= clr_ptr_r;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag for accepted writes outside the text buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oob_err <= 1'b0;
        end else if ((wr_gnt_s != 2'b00) && wr_oob_s) begin
            oob_err <= 1'b1;
        end else begin
            oob_err <= oob_err;
        end
    end

    // Display read pipeline: RAM adds one cycle, the output register the second.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_d1_r  <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= {DATA_W{1'b0}};
        end else begin
            disp_d1_r  <= disp_req;
            disp_valid <= disp_d1_r;
            if (disp_d1_r) begin
                disp_data <= ram_rdata;
            end else begin
                disp_data <= disp_data;
            end
        end
    end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Randomized scoreboard bench for text_ram_arbiter (4x2 buffer so clears and out-of-range writes occur often).
module tb_text_ram_arbiter;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int DEPTH = COLS * ROWS;
    localparam logic [7:0] CLR_CH = 8'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_req = 1'b0;
    logic [10:0] disp_addr = 11'd0;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        wr0_valid = 1'b0, wr1_valid = 1'b0;
    logic        wr0_ready, wr1_ready;
    logic [10:0] wr0_addr = 11'd0, wr1_addr = 11'd0;
    logic [7:0]  wr0_data = 8'd0, wr1_data = 8'd0;
    logic        clr_start = 1'b0;
    logic        clr_busy, clr_done, oob_err;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    text_ram_arbiter #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(11), .DATA_W(8), .CLR_CHAR(CLR_CH)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .oob_err(oob_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int a);
        return (a == 5) ? 8'h41 : 8'((a * 7) + 3);
    endfunction

    // Behavioural single-port RAM with registered read data.
    logic [7:0] ram [0:2047];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    typedef struct {
        int         cyc;
        bit         chk_reg;
        logic       r0, r1, we;
        logic [10:0] addr;
        logic [7:0] wdata;
        logic       busy, done, oob;
    } ctl_t;
    typedef struct { int cyc; logic [7:0] data; } disp_t;

    ctl_t  ctl_q[$];
    disp_t dq[$];

    int total = 0;
    int bad = 0;
    int end_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: buffer contents plus clear progress, error flag and writer preference.
    logic [7:0] mmem [0:2047];
    bit m_known = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_oob = 1'b0, m_pref = 1'b0;
    int m_ptr = 0;

    task automatic step(input bit rst, input bit dreq, input int daddr,
                        input bit v0, input int a0, input bit v1, input int a1, input bit cs);
        ctl_t e;
        bit n_busy, n_done, n_oob, n_pref;
        int n_ptr, g, a;
        logic [7:0] d0, d1, d;
        @(posedge clk);
        #1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        if (rst) dreq = 1'b0;
        rst_n = !rst; disp_req = dreq; disp_addr = 11'(daddr);
        wr0_valid = v0; wr0_addr = 11'(a0); wr0_data = d0;
        wr1_valid = v1; wr1_addr = 11'(a1); wr1_data = d1;
        clr_start = cs;
        e = '{cyc, m_known, 1'b0, 1'b0, 1'b0, 11'd0, 8'd0, m_busy, m_done, m_oob};
        n_busy = m_busy; n_ptr = m_ptr; n_oob = m_oob; n_pref = m_pref; n_done = 1'b0;
        if (rst) begin
            n_busy = 1'b0; n_ptr = 0; n_oob = 1'b0; n_pref = 1'b0;
            while (dq.size() > 0 && dq[dq.size()-1].cyc > cyc) void'(dq.pop_back());
        end else begin
            if (dreq) begin
                e.addr = 11'(daddr);
                dq.push_back('{cyc + 2, mmem[daddr]});
            end else if (m_busy) begin
                e.we = 1'b1; e.addr = 11'(m_ptr); e.wdata = CLR_CH;
                mmem[m_ptr] = CLR_CH;
                if (m_ptr == DEPTH - 1) begin n_busy = 1'b0; n_done = 1'b1; end
                else n_ptr = m_ptr + 1;
            end else if (v0 || v1) begin
                g = (v0 && v1) ? int'(m_pref) : (v1 ? 1 : 0);
                n_pref = (g == 0);
                a = (g == 1) ? a1 : a0;
                d = (g == 1) ? d1 : d0;
                if (g == 1) e.r1 = 1'b1; else e.r0 = 1'b1;
                if (a >= DEPTH) n_oob = 1'b1;
                else begin
                    e.we = 1'b1; e.addr = 11'(a); e.wdata = d;
                    mmem[a] = d;
                end
            end
            if (!m_busy && cs) begin n_busy = 1'b1; n_ptr = 0; end
        end
        ctl_q.push_back(e);
        m_busy = n_busy; m_ptr = n_ptr; m_oob = n_oob; m_pref = n_pref; m_done = n_done;
        if (rst) m_known = 1'b1;
    endtask

    // Monitor: pops expectations as the DUT presents port activity and display data.
    ctl_t me;
    always @(negedge clk) begin
        if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) begin
            me = ctl_q.pop_front();
            chk("wr0_ready", 32'(wr0_ready), 32'(me.r0));
            chk("wr1_ready", 32'(wr1_ready), 32'(me.r1));
            chk("ram_we", 32'(ram_we), 32'(me.we));
            chk("ram_addr", 32'(ram_addr), 32'(me.addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(me.wdata));
            if (me.chk_reg) begin
                chk("clr_busy", 32'(clr_busy), 32'(me.busy));
                chk("clr_done", 32'(clr_done), 32'(me.done));
                chk("oob_err", 32'(oob_err), 32'(me.oob));
            end
        end
        if (cyc >= 2) begin
            if (disp_valid) begin
                if (dq.size() == 0) chk("disp_valid_unexpected", 32'(disp_valid), 32'd0);
                else if (dq[0].cyc != cyc) chk("disp_cycle", 32'(cyc), 32'(dq[0].cyc));
                else begin
                    chk("disp_data", 32'(disp_data), 32'(dq[0].data));
                    void'(dq.pop_front());
                end
            end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                chk("disp_valid_missing", 32'(disp_valid), 32'd1);
                void'(dq.pop_front());
            end
        end
        if (end_cyc != 0 && cyc == end_cyc) begin
            chk("disp_queue_empty", 32'(dq.size()), 32'd0);
            chk("ctl_queue_empty", 32'(ctl_q.size()), 32'd0);
        end
    end

    function automatic int rand_addr();
        return ($urandom_range(0, 19) == 0) ? 2047 : int'($urandom_range(0, 9));
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) mmem[i] = init_val(i);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 2, 1, 3, 0);
        for (int i = 0; i < 20; i++) step(0, 1, i % 8, 1, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 14; i++) step(0, (i == 1) || (i == 4) || (i == 7), i, 1, 4, 1, 6, 0);
        step(0, 0, 0, 0, 0, 1, 2047, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
                 $urandom_range(0, 49) == 0);
        end
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);
        end_cyc = cyc + 1;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Shares one single-port character RAM among three users: the display scan-out fetch, a screen-clear engine, and two write requesters (CPU/UART text writers).
- Sits between the character-generator pixel pipeline and the text buffer.
- Guarantees the display a fixed-latency read every cycle it asks; the remaining cycles go to clear or writes.

Parameters:
- COLS, 64, characters per text row
- ROWS, 32, text rows
- ADDR_W, 11, RAM address width; must satisfy 2**ADDR_W >= COLS*ROWS
- DATA_W, 8, character code width
- CLR_CHAR, 8'h20, code written by the clear engine

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- disp_req  in  1  display fetch request this cycle
- disp_addr  in  ADDR_W  display fetch address
- disp_valid  out  1  display data valid
- disp_data  out  DATA_W  fetched character code
- wr0_valid  in  1  writer 0 request
- wr0_ready  out  1  writer 0 accepted this cycle
- wr0_addr  in  ADDR_W  writer 0 address
- wr0_data  in  DATA_W  writer 0 data
- wr1_valid / wr1_ready / wr1_addr / wr1_data  same as writer 0
- clr_start  in  1  start clearing the whole buffer
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when clear completes
- oob_err  out  1  sticky: a write was accepted with addr >= COLS*ROWS
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, registered in RAM, 1-cycle latency

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset: disp_valid=0, disp_data=0, clr_busy=0, clr_done=0, oob_err=0, FSM=IDLE, clear pointer=0, round-robin pointer=writer 0. While rst_n=0, wr*_ready=0 and ram_we=0.
- Port ownership: exactly one owner per cycle, decided combinationally. Priority order: display > clear > writers.
- Display:
  - disp_req in cycle N drives ram_addr=disp_addr, ram_we=0.
  - In cycle N+2, disp_valid=1 and disp_data holds the registered ram_rdata.
  - Latency is fixed at 2 cycles and independent of any other activity.
  - Back-to-back requests are fully pipelined.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start. The clear pointer loads 0 and clr_busy=1 from the next cycle.
  - In CLEAR, any cycle without disp_req drives ram_we=1, ram_addr=pointer, ram_wdata=CLR_CHAR, then increments the pointer.
  - When disp_req is present, the pointer holds.
  - After writing address COLS*ROWS-1: CLEAR -> IDLE, clr_busy=0, clr_done=1 for exactly one cycle.
  - clr_start during CLEAR is ignored (no restart).
  - Reset during CLEAR returns to IDLE with no clr_done pulse.
- Writers:
  - Eligible only when there is no disp_req and FSM=IDLE; the IDLE cycle that samples clr_start still serves writers.
  - If exactly one writer is valid, it is granted.
  - If both are valid, the writer the round-robin pointer names is granted, and the pointer then moves to the other writer.
  - The pointer changes only on a granted transfer.
  - wrX_ready is combinational and high only for the granted writer; a transfer is wrX_valid & wrX_ready.
  - An in-range accepted write drives ram_we=1, ram_addr=wrX_addr, ram_wdata=wrX_data.
  - addr >= COLS*ROWS: the write is accepted (ready=1) but ram_we=0, and oob_err is set until reset.
- Idle cycle (no owner): ram_we=0, ram_addr=0, ram_wdata=0.
- Width rules: the clear pointer is ADDR_W wide and is compared against the constant COLS*ROWS-1; there is no wrap beyond the buffer.

Decomposition:
- Shared package vga_text_pkg holds:
  - COLS, ROWS, ADDR_W, DATA_W, CLR_CHAR defaults
  - the derived constant TEXT_DEPTH = COLS*ROWS
  - the clear FSM state enum (IDLE, CLEAR)
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with a grant-enable input and a pointer that updates on accept.
- The clear FSM, priority mux and display read pipeline stay in the top module.

Test Plan:
- Reset, then disp_req at cycle 10 with addr 0x005 while the RAM holds 0x41 there -> disp_valid=1 and disp_data=0x41 exactly at cycle 12; ram_we=0 at cycle 10.
- Hold wr0_valid and wr1_valid high with addrs 0x010/0x011 and no display traffic for 4 cycles -> grants alternate 0,1,0,1 starting with writer 0; RAM receives four writes in that order.
- Assert disp_req every cycle for 20 cycles while wr0_valid=1 -> wr0_ready=0 for all 20 cycles; the first write lands the cycle after disp_req drops; display data is valid every cycle with 2-cycle latency.
- Pulse clr_start with COLS=4, ROWS=2 and insert disp_req on 3 separate cycles -> 8 CLR_CHAR writes to addresses 0..7; clr_busy high for 11 cycles; clr_done pulses once; writers are blocked throughout.
- Accept a wr1 transfer at addr 0x7FF with default params -> wr1_ready=1, ram_we=0, oob_err rises and stays high until reset.
- Apply reset in the middle of a clear at pointer 3 -> clr_busy=0, no clr_done; a subsequent clr_start restarts the clear from address 0.
